// File: rtl/hazard_scoreboard_if.sv
// Connects the ID-stage issue request and the scoreboard's stall and write-back view.
// The master side drives ID/pipeline control; the slave side is hazard_scoreboard.
interface hazard_scoreboard_if #(
    parameter int unsigned CNT_W = 16
);
    logic             freeze;
    logic             flush;
    logic             id_valid;
    logic [1:0]       id_rs;
    logic [1:0]       id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic             id_reg_write;
    logic [1:0]       id_write_reg;
    logic             id_is_load;
    logic             stall;
    logic             reg_write_mem;
    logic [1:0]       write_reg_mem;
    logic             reg_write_wb;
    logic [1:0]       write_reg_wb;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output freeze, flush, id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_reg_write, id_write_reg, id_is_load,
        input  stall, reg_write_mem, write_reg_mem, reg_write_wb, write_reg_wb,
               stall_count
    );

    modport slave (
        input  freeze, flush, id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_reg_write, id_write_reg, id_is_load,
        output stall, reg_write_mem, write_reg_mem, reg_write_wb, write_reg_wb,
               stall_count
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tracks EX/MEM/WB register writers and stalls ID when forwarding cannot cover a dependency.
// HAZARD_DATA_FORWARDING_EN: defined -> only load-use stalls; undefined -> any EX/MEM writer stalls.
module hazard_scoreboard #(
    parameter int unsigned CNT_W = 16
) (
    input logic                clk,
    input logic                reset_n,
    hazard_scoreboard_if.slave sb
);
    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic [1:0] dest;
        logic       is_load;
    } slot_t;

    slot_t            ex_q, ex_d, mem_q, wb_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hit_rs, hit_rt, stall, issue;
    logic             unused_load_bits;

    function automatic logic writes(input slot_t s, input logic [1:0] r);
        return s.valid & s.reg_write & (s.dest == r);
    endfunction

    always_comb begin
`ifdef HAZARD_DATA_FORWARDING_EN
        hit_rs = writes(ex_q, sb.id_rs) & ex_q.is_load;
        hit_rt = writes(ex_q, sb.id_rt) & ex_q.is_load;
`else
        hit_rs = writes(ex_q, sb.id_rs) | writes(mem_q, sb.id_rs);
        hit_rt = writes(ex_q, sb.id_rt) | writes(mem_q, sb.id_rt);
`endif
        stall = sb.id_valid & ~sb.flush &
                ((sb.id_use_rs & hit_rs) | (sb.id_use_rt & hit_rt));
        issue = sb.id_valid & ~stall & ~sb.flush;

        ex_d = '0;
        if (issue) begin
            ex_d.valid     = 1'b1;
            ex_d.reg_write = sb.id_reg_write;
            ex_d.dest      = sb.id_write_reg;
            ex_d.is_load   = sb.id_is_load;
        end

        cnt_d = cnt_q;
        if (stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            cnt_q <= '0;
        end else if (!sb.freeze) begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    assign sb.stall         = stall;
    assign sb.reg_write_mem = mem_q.valid & mem_q.reg_write;
    assign sb.write_reg_mem = mem_q.dest;
    assign sb.reg_write_wb  = wb_q.valid & wb_q.reg_write;
    assign sb.write_reg_wb  = wb_q.dest;
    assign sb.stall_count   = cnt_q;

    // is_load is carried down the pipe for visibility but only EX's copy can matter.
    assign unused_load_bits = ^{ex_q.is_load, mem_q.is_load, wb_q.is_load};
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized scoreboard bench for hazard_scoreboard against an issue-history reference model.
// Runs a 16-bit-counter DUT and a 4-bit-counter DUT on identical stimulus.
module tb_hazard_scoreboard;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.CNT_W(16)) sb16 ();
    hazard_scoreboard_if #(.CNT_W(4))  sb4 ();

    hazard_scoreboard #(.CNT_W(16)) dut   (.clk(clk), .reset_n(reset_n), .sb(sb16));
    hazard_scoreboard #(.CNT_W(4))  dut4  (.clk(clk), .reset_n(reset_n), .sb(sb4));

    assign sb4.freeze       = sb16.freeze;
    assign sb4.flush        = sb16.flush;
    assign sb4.id_valid     = sb16.id_valid;
    assign sb4.id_rs        = sb16.id_rs;
    assign sb4.id_rt        = sb16.id_rt;
    assign sb4.id_use_rs    = sb16.id_use_rs;
    assign sb4.id_use_rt    = sb16.id_use_rt;
    assign sb4.id_reg_write = sb16.id_reg_write;
    assign sb4.id_write_reg = sb16.id_write_reg;
    assign sb4.id_is_load   = sb16.id_is_load;

    // Reference model: history of what entered EX on each advancing edge, newest last.
    typedef struct {
        bit       v;
        bit       w;
        bit [1:0] d;
        bit       ld;
    } instr_t;

    typedef struct {
        bit          rst;
        bit          stall;
        bit          rwm;
        bit [1:0]    wrm;
        bit          rww;
        bit [1:0]    wrw;
        int unsigned cnt;
    } exp_t;

    instr_t      hist[$];
    exp_t        exp_q[$];
    int unsigned cnt_m;
    bit          last_stall;
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    function automatic bit wr(input instr_t i, input bit [1:0] r);
        return i.v && i.w && (i.d == r);
    endfunction

    // A dependency needs a stall if its producer entered EX 1 or 2 advances ago,
    // unless forwarding is present, in which case only a load 1 advance ago blocks.
    function automatic bit hitm(input bit [1:0] r);
        int n = hist.size();
`ifdef HAZARD_DATA_FORWARDING_EN
        return wr(hist[n-1], r) && hist[n-1].ld;
`else
        for (int k = 1; k <= 2; k++)
            if (wr(hist[n-k], r)) return 1'b1;
        return 1'b0;
`endif
    endfunction

    function automatic void model_reset();
        hist.delete();
        for (int k = 0; k < 3; k++) hist.push_back('{v:1'b0, w:1'b0, d:2'b00, ld:1'b0});
        cnt_m = 0;
        last_stall = 1'b0;
    endfunction

    function automatic void model_advance();
        instr_t e;
        bit     iss;
        if (sb16.freeze) return;
        iss = sb16.id_valid && !last_stall && !sb16.flush;
        e = '{v:1'b0, w:1'b0, d:2'b00, ld:1'b0};
        if (iss) e = '{v:1'b1, w:sb16.id_reg_write, d:sb16.id_write_reg, ld:sb16.id_is_load};
        hist.push_back(e);
        void'(hist.pop_front());
        if (last_stall && cnt_m < 65535) cnt_m++;
    endfunction

    task automatic push_expect();
        exp_t e;
        int   n;
        if (!reset_n) model_reset();
        n = hist.size();
        e.rst   = !reset_n;
        e.stall = reset_n && sb16.id_valid && !sb16.flush &&
                  ((sb16.id_use_rs && hitm(sb16.id_rs)) || (sb16.id_use_rt && hitm(sb16.id_rt)));
        e.rwm   = hist[n-2].v && hist[n-2].w;
        e.wrm   = hist[n-2].d;
        e.rww   = hist[n-3].v && hist[n-3].w;
        e.wrw   = hist[n-3].d;
        e.cnt   = cnt_m;
        last_stall = e.stall;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset_n) model_advance();
        #1;
    endtask

    task automatic drive(input bit v, input bit [1:0] rs, input bit urs, input bit [1:0] rt,
                         input bit urt, input bit w, input bit [1:0] d, input bit ld,
                         input bit frz, input bit fl);
        sb16.id_valid = v;     sb16.id_rs = rs;        sb16.id_use_rs = urs;
        sb16.id_rt = rt;       sb16.id_use_rt = urt;   sb16.id_reg_write = w;
        sb16.id_write_reg = d; sb16.id_is_load = ld;   sb16.freeze = frz;
        sb16.flush = fl;
    endtask

    task automatic step(input bit v, input bit [1:0] rs, input bit urs, input bit [1:0] rt,
                        input bit urt, input bit w, input bit [1:0] d, input bit ld,
                        input bit frz, input bit fl);
        tick();
        drive(v, rs, urs, rt, urt, w, d, ld, frz, fl);
        push_expect();
    endtask

    task automatic rand_step();
        bit hold;
        tick();
        hold = sb16.freeze || last_stall;
        if (!hold || !reset_n) begin
            sb16.id_valid     = ($urandom_range(99) < 80);
            sb16.id_rs        = 2'($urandom);
            sb16.id_rt        = 2'($urandom);
            sb16.id_use_rs    = 1'($urandom);
            sb16.id_use_rt    = 1'($urandom);
            sb16.id_reg_write = ($urandom_range(99) < 75);
            sb16.id_write_reg = 2'($urandom);
            sb16.id_is_load   = ($urandom_range(99) < 40);
        end
        sb16.freeze = ($urandom_range(99) < 12);
        sb16.flush  = ($urandom_range(99) < 8);
        push_expect();
    endtask

    task automatic check(input string name, input int unsigned act, input int unsigned req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, req);
        end
    endtask

    // Monitor: the DUT presents its outputs every cycle; compare mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("stall", 32'(sb16.stall), 32'(e.stall));
                check("stall_cnt4", 32'(sb4.stall), 32'(e.stall));
                check("reg_write_mem", 32'(sb16.reg_write_mem), 32'(e.rwm));
                check("reg_write_wb", 32'(sb16.reg_write_wb), 32'(e.rww));
                if (e.rwm || e.rst) check("write_reg_mem", 32'(sb16.write_reg_mem), 32'(e.wrm));
                if (e.rww || e.rst) check("write_reg_wb", 32'(sb16.write_reg_wb), 32'(e.wrw));
                check("stall_count", 32'(sb16.stall_count), e.cnt);
                check("stall_count_sat4", 32'(sb4.stall_count), (e.cnt > 15) ? 15 : e.cnt);
            end
        end
    end

    initial begin
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Reset held with random inputs.
        for (int i = 0; i < 4; i++) rand_step();
        tick(); reset_n = 1'b1; drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); push_expect();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Load r1 then a consumer of rs=1, held in ID until it issues.
        step(1, 0, 0, 0, 0, 1, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 1, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // ALU writes r2, next reads rt=2.
        step(1, 0, 0, 0, 0, 1, 2, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 2, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // ALU writes r3, independent instruction, then consumer of r3.
        step(1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
        step(1, 1, 1, 1, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Load-use stall frozen 3 cycles, then flushed.
        step(1, 0, 0, 0, 0, 1, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 1, 1, 1, 0, 0, 0, 1, 0);
        step(1, 1, 1, 1, 1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Self-dependent load r3 <- r3 re-issued repeatedly: steady stalls past 15.
        for (int i = 0; i < 50; i++) step(1, 3, 1, 3, 1, 1, 3, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 1500; i++) rand_step();

        // Asynchronous reset in the middle of traffic.
        tick(); reset_n = 1'b0; push_expect();
        rand_step();
        tick(); reset_n = 1'b1; drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); push_expect();

        for (int i = 0; i < 800; i++) rand_step();

        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
